// File: rtl/sel_arb_pkg.sv
// Shared types, constants and the round-robin search used by sel_arbiter.
package sel_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int NUM_LINES = 64;
  localparam int ADDR_W    = 6;
  localparam int MAX_REQ   = 8;

  // Returns {found, index}; scans cyclically from last+1 so the nearest valid requester wins.
  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] last,
                                         input int nreq);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % nreq);
      res = ((k <= nreq) && valid[idx]) ? {1'b1, idx} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot64_dec.sv
// Pure 6-to-64 one-hot decoder for the select lines.
module onehot64_dec
  import sel_arb_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  output logic [NUM_LINES-1:0] onehot
);

  assign onehot = {{(NUM_LINES-1){1'b0}}, 1'b1} << addr;

endmodule

// File: rtl/sel_arbiter.sv
// Round-robin arbiter that grants one requester a decoded select line for a
// programmable number of cycles, with flush and back-to-back grants.
module sel_arbiter
  import sel_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int HOLD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [HOLD_W-1:0]      hold_cycles,
  input  logic                   flush,
  output logic [NREQ-1:0]        req_ready,
  output logic [NUM_LINES-1:0]   sel,
  output logic                   sel_valid,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  state_t              state_r, state_s;
  logic [2:0]          last_grant_r, last_grant_s;
  logic [HOLD_W-1:0]   cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [2:0]          grant_id_r, grant_id_s;
  logic [7:0]          valid8_s;
  logic [3:0]          pick_s;
  logic                window_s;
  logic                accept_s;
  logic [NUM_LINES-1:0] dec_s;

  // Widen the request vector to the fixed search width.
  always_comb begin
    valid8_s = 8'd0;
    valid8_s[NREQ-1:0] = req_valid;
  end

  assign pick_s   = rr_pick(valid8_s, last_grant_r, NREQ);
  assign window_s = (state_r == IDLE) || (cnt_r == {HOLD_W{1'b0}});
  // Reset is folded in so ready stays low while the block is held in reset.
  assign accept_s = rst_n && window_s && !flush && pick_s[3];
  assign req_ready = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << pick_s[2:0]) : {NREQ{1'b0}};

  // Next-state: flush beats accept, accept beats countdown, otherwise drop to IDLE.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    addr_s       = addr_r;
    grant_id_s   = grant_id_r;
    if (flush) begin
      state_s = IDLE;
      cnt_s   = {HOLD_W{1'b0}};
    end else if (accept_s) begin
      state_s      = ACTIVE;
      cnt_s        = hold_cycles;
      addr_s       = req_addr[ADDR_W*int'(pick_s[2:0]) +: ADDR_W];
      grant_id_s   = pick_s[2:0];
      last_grant_s = pick_s[2:0];
    end else if ((state_r == ACTIVE) && (cnt_r != {HOLD_W{1'b0}})) begin
      cnt_s = cnt_r - HOLD_W'(1);
    end else begin
      state_s = IDLE;
    end
  end

  // State, pointer, counter and latched grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 3'(NREQ - 1);
      cnt_r        <= {HOLD_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      grant_id_r   <= 3'd0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      addr_r       <= addr_s;
      grant_id_r   <= grant_id_s;
    end
  end

  onehot64_dec u_dec (
    .addr   (addr_r),
    .onehot (dec_s)
  );

  assign sel_valid = (state_r == ACTIVE);
  assign busy      = (state_r == ACTIVE);
  assign grant_id  = grant_id_r;
  assign sel       = sel_valid ? dec_s : {NUM_LINES{1'b0}};

endmodule

// File: tb/tb_sel_arbiter.sv
// Self-checking bench for sel_arbiter: vector table, directed corner sequences
// and a randomized run against a remaining-cycles reference model.
module tb_sel_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [23:0] req_addr;
  logic [3:0]  hold_cycles;
  logic        flush;
  logic [3:0]  req_ready;
  logic [63:0] sel;
  logic        sel_valid;
  logic [2:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sel_arbiter #(.NREQ(4), .HOLD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .hold_cycles (hold_cycles),
    .flush       (flush),
    .req_ready   (req_ready),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [23:0] addr;
    logic [3:0]  hold;
    logic        fl;
    logic [3:0]  e_ready;
    logic        e_sv;
    logic [2:0]  e_gid;
    logic [5:0]  e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [23:0] a, input logic [3:0] h,
                              input logic f, input logic [3:0] er, input logic esv,
                              input logic [2:0] eg, input logic [5:0] ea);
    vec_t r;
    r.valid = v; r.addr = a; r.hold = h; r.fl = f;
    r.e_ready = er; r.e_sv = esv; r.e_gid = eg; r.e_addr = ea;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [23:0] a, input logic [3:0] h,
                       input logic f);
    req_valid = v; req_addr = a; hold_cycles = h; flush = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: remaining active cycles including the current one.
  int         m_left;
  int         m_last;
  int         m_gid;
  logic [5:0] m_addr;

  initial begin
    logic [3:0]  v;
    logic [23:0] a;
    logic [3:0]  h;
    logic        f;
    logic [3:0]  er;
    bit          found;
    int          w;

    rst_n = 1'b0;
    drive(4'b1111, 24'hFFFFFF, 4'd3, 1'b0);
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_sel", sel, 64'd0);
    chk("rst_sel_valid", 64'(sel_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    do_reset();

    // Round robin, then single request, then boundary addresses.
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 4'd0, 1'b0,
                       4'(4'b0001 << i % 4), (i > 0), 3'((i + 3) % 4), 6'((i + 3) % 4)));
    end
    tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b1, 3'd0, 6'd0));
    tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 3'd0, 6'd0));
    tbl.push_back(mk(4'b0001, {18'd0, 6'd37}, 4'd2, 1'b0, 4'b0001, 1'b0, 3'd0, 6'd0));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b1, 3'd0, 6'd37));
    end
    tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 3'd0, 6'd0));
    tbl.push_back(mk(4'b0010, {6'd0, 6'd0, 6'd0, 6'd0}, 4'd0, 1'b0, 4'b0010, 1'b0, 3'd0, 6'd0));
    tbl.push_back(mk(4'b0010, {6'd0, 6'd0, 6'd63, 6'd0}, 4'd0, 1'b0, 4'b0010, 1'b1, 3'd1, 6'd0));
    tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b1, 3'd1, 6'd63));
    tbl.push_back(mk(4'b0000, 24'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 3'd0, 6'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].addr, tbl[i].hold, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_sel_valid", i), 64'(sel_valid), 64'(tbl[i].e_sv));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_sv));
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].e_sv ? (64'd1 << tbl[i].e_addr) : 64'd0);
      if (tbl[i].e_sv) chk($sformatf("tbl%0d_gid", i), 64'(grant_id), 64'(tbl[i].e_gid));
      next_cycle();
    end

    // Flush on the 2nd cycle of a hold=5 grant (pointer is 1 here).
    drive(4'b0001, {18'd0, 6'd10}, 4'd5, 1'b0);
    @(negedge clk); chk("fl_accept_ready", 64'(req_ready), 64'b0001); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("fl_active1", 64'(sel_valid), 64'd1); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b1);
    @(negedge clk); chk("fl_active2", 64'(sel_valid), 64'd1); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("fl_after_sv", 64'(sel_valid), 64'd0);
    chk("fl_after_busy", 64'(busy), 64'd0);
    chk("fl_after_sel", sel, 64'd0);
    next_cycle();
    // Flush coincident with a waiting request.
    drive(4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, 4'd0, 1'b1);
    @(negedge clk); chk("fl_wait_ready", 64'(req_ready), 64'd0); next_cycle();
    drive(4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, 4'd0, 1'b0);
    @(negedge clk);
    chk("fl_noaccept_sv", 64'(sel_valid), 64'd0);
    chk("fl_retry_ready", 64'(req_ready), 64'b0100);
    next_cycle();
    drive(4'b1001, 24'd0, 4'd0, 1'b1);
    @(negedge clk);
    chk("fl_retry_sel", sel, 64'd1 << 5);
    chk("fl_retry_gid", 64'(grant_id), 64'd2);
    chk("fl_win_ready", 64'(req_ready), 64'd0);
    next_cycle();
    drive(4'b1001, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("fl_ptr_ready", 64'(req_ready), 64'b1000); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("fl_ptr_gid", 64'(grant_id), 64'd3); next_cycle();

    // Asynchronous reset in the middle of a grant.
    drive(4'b0010, {6'd0, 6'd0, 6'd20, 6'd0}, 4'd7, 1'b0);
    @(negedge clk); chk("rm_ready", 64'(req_ready), 64'b0010); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("rm_sel", sel, 64'd1 << 20); next_cycle();
    req_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("rm_async_sel", sel, 64'd0);
    chk("rm_async_sv", 64'(sel_valid), 64'd0);
    chk("rm_async_busy", 64'(busy), 64'd0);
    chk("rm_async_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 4'd0, 1'b0);
    @(negedge clk); chk("rm_prio_ready", 64'(req_ready), 64'b0001); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("rm_prio_gid", 64'(grant_id), 64'd0); next_cycle();

    // Requester 2 withdraws before its window opens; pointer must stay at 0.
    drive(4'b0001, {18'd0, 6'd1}, 4'd3, 1'b0);
    @(negedge clk); chk("wd_accept", 64'(req_ready), 64'b0001); next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive((i < 2) ? 4'b0100 : 4'b0000, {6'd0, 6'd9, 6'd0, 6'd0}, 4'd0, 1'b0);
      @(negedge clk);
      chk($sformatf("wd_ready%0d", i), 64'(req_ready), 64'd0);
      chk($sformatf("wd_gid%0d", i), 64'(grant_id), 64'd0);
      next_cycle();
    end
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("wd_idle", 64'(sel_valid), 64'd0); next_cycle();
    drive(4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 4'd0, 1'b0);
    @(negedge clk); chk("wd_ptr_ready", 64'(req_ready), 64'b0010); next_cycle();
    drive(4'b0000, 24'd0, 4'd0, 1'b0);
    @(negedge clk); chk("wd_ptr_gid", 64'(grant_id), 64'd1); next_cycle();

    // Randomized run against the reference model.
    do_reset();
    m_left = 0; m_last = 3; m_gid = 0; m_addr = 6'd0;
    for (int c = 0; c < 600; c++) begin
      v = 4'($urandom_range(0, 15));
      a = 24'($urandom);
      h = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      f = ($urandom_range(0, 11) == 0);
      drive(v, a, h, f);
      @(negedge clk);
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && v[(m_last + k) % 4]) begin
          found = 1'b1;
          w = (m_last + k) % 4;
        end
      end
      er = ((m_left <= 1) && !f && found) ? 4'(4'b0001 << w) : 4'b0000;
      chk("rnd_ready", 64'(req_ready), 64'(er));
      chk("rnd_sel_valid", 64'(sel_valid), 64'(m_left > 0));
      chk("rnd_busy", 64'(busy), 64'(m_left > 0));
      chk("rnd_sel", sel, (m_left > 0) ? (64'd1 << m_addr) : 64'd0);
      if (m_left > 0) chk("rnd_gid", 64'(grant_id), 64'(m_gid));
      if (f) begin
        m_left = 0;
      end else if (er != 4'b0000) begin
        m_left = int'(h) + 1;
        m_addr = a[6*w +: 6];
        m_gid  = w;
        m_last = w;
      end else if (m_left > 0) begin
        m_left--;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
